// File: rtl/nios1_led_pwm_driver.sv
// LED pin driver: global PWM brightness and per-bit blink on the PIO pattern.
// Avalon-MM slave with zero wait states holds the brightness and blink setup.
module nios1_led_pwm_driver (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  localparam logic [2:0] A_BRIGHT = 3'd0;
  localparam logic [2:0] A_PRESC  = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_HALF   = 3'd3;
  localparam logic [2:0] A_STATUS = 3'd4;

  logic [7:0]  bright;
  logic [15:0] prescale;
  logic [7:0]  blink_mask;
  logic [15:0] blink_half;

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [15:0] blk_cnt;
  logic        phase;

  logic wr;
  logic we_bright;
  logic we_presc;
  logic we_mask;
  logic we_half;
  logic resync;

  logic tick;
  logic wrap;
  logic blk_done;
  logic pwm_on;
  logic [7:0] blink_en;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign wr        = chipselect & ~write_n;
  assign we_bright = wr && (address == A_BRIGHT);
  assign we_presc  = wr && (address == A_PRESC);
  assign we_mask   = wr && (address == A_MASK);
  assign we_half   = wr && (address == A_HALF);
  assign resync    = wr && (address == A_STATUS)
                        && writedata[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bright     <= 8'hFF;
      prescale   <= 16'd0;
      blink_mask <= 8'd0;
      blink_half <= 16'd0;
    end else begin
      if (we_bright) bright     <= writedata[7:0];
      if (we_presc)  prescale   <= writedata[15:0];
      if (we_mask)   blink_mask <= writedata[7:0];
      if (we_half)   blink_half <= writedata[15:0];
    end
  end

  // >= so that shrinking PRESCALE below the count ticks at once
  assign tick     = (pre_cnt >= prescale);
  assign wrap     = tick && (pwm_cnt == 8'hFF);
  assign blk_done = (blk_cnt >= blink_half);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= 16'd0;
      pwm_cnt <= 8'd0;
      blk_cnt <= 16'd0;
      phase   <= 1'b1;
    end else if (resync) begin
      pre_cnt <= 16'd0;
      pwm_cnt <= 8'd0;
      blk_cnt <= 16'd0;
      phase   <= 1'b1;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap) begin
        if (blk_done) begin
          blk_cnt <= 16'd0;
          phase   <= ~phase;
        end else begin
          blk_cnt <= blk_cnt + 16'd1;
        end
      end
    end
  end

  assign pwm_on   = (bright == 8'hFF) || (pwm_cnt < bright);
  assign blink_en = ~blink_mask | {8{phase}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out <= 8'h00;
    end else begin
      led_out <= led_in & {8{pwm_on}} & blink_en;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      A_BRIGHT: readdata = {24'd0, bright};
      A_PRESC:  readdata = {16'd0, prescale};
      A_MASK:   readdata = {24'd0, blink_mask};
      A_HALF:   readdata = {16'd0, blink_half};
      A_STATUS: readdata = {16'd0, pwm_cnt, 7'd0, phase};
      default:  readdata = 32'd0;
    endcase
  end

endmodule
